// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix scan driver with binary-code-modulated colour depth.
// Each row is shifted once per bit plane; plane p is lit for BASE_DISPLAY<<p cycles.
module hub75_bcm_driver #(
   parameter int COLS         = 32,
   parameter int ROW_BITS     = 4,
   parameter int DEPTH        = 4,
   parameter int BASE_DISPLAY = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   output logic [ROW_BITS+$clog2(COLS)-1:0]  fb_addr,
   input  logic [3*DEPTH-1:0]                fb_rgb0,
   input  logic [3*DEPTH-1:0]                fb_rgb1,
   output logic                              R0,
   output logic                              G0,
   output logic                              B0,
   output logic                              R1,
   output logic                              G1,
   output logic                              B1,
   output logic [ROW_BITS-1:0]               row_address,
   output logic                              outclk,
   output logic                              latch,
   output logic                              eo,
   output logic                              frame_done
);
   localparam int COL_BITS = $clog2(COLS);
   localparam int PL_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int MAX_DISP = BASE_DISPLAY << (DEPTH - 1);
   localparam int CNT_W    = $clog2(MAX_DISP + 1);

   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
   localparam logic [PL_BITS-1:0]  LAST_PL  = PL_BITS'(DEPTH - 1);
   localparam logic [ROW_BITS-1:0] LAST_ROW = '1;

   typedef enum logic [2:0] {IDLE, SETUP, LOAD, CLK_HI, BLANK, LATCH, DISPLAY} state_t;

   state_t              state, state_nx;
   logic [ROW_BITS-1:0] cur_row;
   logic [COL_BITS-1:0] col;
   logic [PL_BITS-1:0]  plane;
   logic [CNT_W-1:0]    disp_cnt;
   logic [DEPTH-1:0]    pl_mask;
   logic                disp_end;

   // One-hot plane mask keeps the bit select free of index-width concerns.
   assign pl_mask  = DEPTH'(1) << plane;
   assign disp_end = (state == DISPLAY) && (disp_cnt == CNT_W'(1));
   assign fb_addr  = {cur_row, col};

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable) state_nx = SETUP;
         SETUP:   state_nx = LOAD;
         LOAD:    state_nx = CLK_HI;
         CLK_HI:  state_nx = (col == LAST_COL) ? BLANK : SETUP;
         BLANK:   state_nx = LATCH;
         LATCH:   state_nx = DISPLAY;
         DISPLAY: if (disp_end) state_nx = enable ? SETUP : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      outclk = 1'b0;
      latch  = 1'b0;
      eo     = 1'b1;
      case (state)
         CLK_HI:  outclk = 1'b1;
         LATCH:   latch  = 1'b1;
         DISPLAY: eo     = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_row     <= '0;
         col         <= '0;
         plane       <= '0;
         disp_cnt    <= '0;
         row_address <= '0;
         frame_done  <= 1'b0;
         {R0, G0, B0, R1, G1, B1} <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: if (enable) col <= '0;
            LOAD: begin
               R0 <= |(fb_rgb0[2*DEPTH +: DEPTH] & pl_mask);
               G0 <= |(fb_rgb0[DEPTH   +: DEPTH] & pl_mask);
               B0 <= |(fb_rgb0[0       +: DEPTH] & pl_mask);
               R1 <= |(fb_rgb1[2*DEPTH +: DEPTH] & pl_mask);
               G1 <= |(fb_rgb1[DEPTH   +: DEPTH] & pl_mask);
               B1 <= |(fb_rgb1[0       +: DEPTH] & pl_mask);
            end
            CLK_HI: if (col != LAST_COL) col <= col + 1'b1;
            BLANK:  row_address <= cur_row;
            LATCH:  disp_cnt <= CNT_W'(BASE_DISPLAY) << plane;
            DISPLAY: begin
               disp_cnt <= disp_cnt - 1'b1;
               if (disp_end) begin
                  col <= '0;
                  if (plane != LAST_PL) begin
                     plane <= plane + 1'b1;
                  end else begin
                     plane   <= '0;
                     cur_row <= cur_row + 1'b1;
                     if (cur_row == LAST_ROW) frame_done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/hub75_bcm_driver.md
Name: hub75_bcm_driver

Overview:
Parametrised HUB75 LED-matrix scan driver that replaces the fixed-pattern shifter. It reads pixel colours from an external dual-half framebuffer and drives the R0/G0/B0 (top half) and R1/G1/B1 (bottom half) shift lines. Colour depth uses binary-code modulation: each row is shifted once per bit plane, and each plane is displayed for BASE_DISPLAY<<plane cycles. It sits between the framebuffer RAM and the panel connector pins.

Parameters:
COLS, 32, pixels per row shifted per plane (power of two, >=2)
ROW_BITS, 4, width of row_address; rows scanned = 2**ROW_BITS
DEPTH, 4, bits per colour channel (1..8)
BASE_DISPLAY, 32, display cycles for plane 0 (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run scan; low parks the driver blanked at the next plane boundary
fb_addr  out  ROW_BITS+$clog2(COLS)  framebuffer read address {cur_row, col}
fb_rgb0  in  3*DEPTH  top-half pixel {R,G,B}, each DEPTH bits; valid 1 cycle after fb_addr
fb_rgb1  in  3*DEPTH  bottom-half pixel, same packing and timing
R0, G0, B0, R1, G1, B1  out  1 each  registered panel data bits
row_address  out  ROW_BITS  panel row select (registered)
outclk  out  1  panel shift clock
latch  out  1  panel latch strobe
eo  out  1  output enable, active-high blank (1 = LEDs off)
frame_done  out  1  one-cycle pulse when the last plane of the last row finishes

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it wins over every other input.
- Reset values:
  - state IDLE; cur_row, col, plane and display counter all 0
  - R0..B1 = 0, row_address = 0, fb_addr = 0
  - outclk = 0, latch = 0, eo = 1, frame_done = 0
- Reset mid-operation returns all outputs to these values on the next edge. The scan then restarts at row 0, plane 0.
- States: IDLE, SETUP, LOAD, CLK_HI, BLANK, LATCH, DISPLAY.
- IDLE:
  - eo = 1.
  - If enable = 1, go to SETUP with col = 0. cur_row and plane are held, so the scan resumes where it parked.
- SETUP: fb_addr = {cur_row, col}; go to LOAD.
- LOAD:
  - The framebuffer data is valid in this cycle.
  - At the end of the cycle, register R0 = fb_rgb0[2*DEPTH+plane], G0 = fb_rgb0[DEPTH+plane], B0 = fb_rgb0[plane]. R1/G1/B1 are loaded the same way from fb_rgb1.
  - Go to CLK_HI.
- CLK_HI:
  - outclk = 1; data stays stable.
  - If col == COLS-1, go to BLANK. Otherwise col increments and the next state is SETUP.
  - Each column costs 3 cycles; every outclk pulse is exactly 1 cycle high.
- BLANK: eo = 1; row_address <= cur_row; go to LATCH.
- LATCH: latch = 1, eo = 1; load display counter with BASE_DISPLAY<<plane; go to DISPLAY.
- DISPLAY:
  - eo = 0 for exactly BASE_DISPLAY<<plane cycles.
  - The counter width is the minimum needed to hold BASE_DISPLAY<<(DEPTH-1).
- End of DISPLAY, advance plane and row:
  - If plane < DEPTH-1: plane++.
  - Otherwise: plane = 0 and cur_row++, wrapping 2**ROW_BITS-1 -> 0. On the wrap, frame_done = 1 for the first cycle after DISPLAY.
- End of DISPLAY, next state: SETUP with col = 0 if enable = 1, else IDLE. enable is ignored inside a plane.
- eo is 1 in every state except DISPLAY. Shifting always occurs blanked.
- outclk, latch and eo decode from the state register only; there are no combinational paths from the inputs.
- Cycles per plane: 3*COLS + 2 + (BASE_DISPLAY<<plane). Entering from IDLE adds 1 cycle.

Test Plan:
- Reset, then enable = 1 (defaults):
  - 32 outclk pulses per plane
  - eo-low windows of 32, 64, 128, 256 cycles, in that order
  - plane period 130/162/226/354 cycles
  - one latch pulse per plane
- Framebuffer model with row 3, col 5 top R = 4'b1010 and all else 0:
  - R0 = 1 during the 6th outclk of row 3, planes 1 and 3 only
  - R0 = 0 everywhere else
- Free run over 64 planes: row_address steps 0..15, each value held across 4 planes, wrapping to 0. frame_done pulses exactly once, after row 15 plane 3 DISPLAY.
- Drop enable during a plane-2 shift:
  - the plane completes (256 display cycles are not owed; its own 128 cycles complete), then IDLE with eo = 1
  - re-enable: the next latched data is plane 3 of the same row
- Assert reset during CLK_HI of col 10: next cycle all outputs are at reset values; after release the first fb_addr = 0.
- COLS=64, DEPTH=1, BASE_DISPLAY=8: 64 outclk pulses, eo low 8 cycles, row advances every plane; period 202 cycles.
